// File: rtl/bp_cce_ucode_loader.sv
// CCE microcode loader: streams N instructions into the CCE instruction RAM and
// optionally reads them back, comparing XOR checksums of written and read data.
module bp_cce_ucode_loader #(
    parameter int cce_pc_width_p    = 8,
    parameter int cce_instr_width_p = 48,
    parameter int verify_p          = 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         start_i,
    input  logic [cce_pc_width_p:0]      num_instr_i,
    input  logic [cce_instr_width_p-1:0] instr_data_i,
    input  logic                         instr_v_i,
    output logic                         instr_ready_o,
    output logic                         ucode_v_o,
    output logic                         ucode_w_o,
    output logic [cce_pc_width_p-1:0]    ucode_addr_o,
    output logic [cce_instr_width_p-1:0] ucode_data_o,
    input  logic [cce_instr_width_p-1:0] ucode_data_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         error_o
);
    // state | meaning
    // IDLE  | waiting for start_i after reset
    // WRITE | one RAM write per stream handshake
    // READ  | one readback per cycle, folding returned data into rd_csum
    // DRAIN | fold the last read word and resolve error
    // DONE  | load complete, error_o valid, start_i restarts
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [cce_pc_width_p:0] one_lp = 1;

    state_e                         state_r, state_n;
    logic [cce_pc_width_p:0]        cnt_r, num_r, num_m1;
    logic [cce_instr_width_p-1:0]   wr_csum_r, rd_csum_r;
    logic                           rd_pend_r, error_r;
    logic                           last_w;

    // Full-width compare so N = 2^cce_pc_width_p ends at the top address without wrapping.
    assign num_m1 = num_r - one_lp;
    assign last_w = (cnt_r == num_m1);

    always_ff @(posedge clk_i) begin
        if (!reset_i) state_r <= S_IDLE;
        else          state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            S_IDLE, S_DONE: if (start_i) state_n = (num_instr_i == '0) ? S_DONE : S_WRITE;
            S_WRITE:        if (instr_v_i && last_w) state_n = (verify_p != 0) ? S_READ : S_DONE;
            S_READ:         if (last_w) state_n = S_DRAIN;
            S_DRAIN:        state_n = S_DONE;
            default:        state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cnt_r     <= '0;
            num_r     <= '0;
            wr_csum_r <= '0;
            rd_csum_r <= '0;
            rd_pend_r <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            rd_pend_r <= (state_r == S_READ);
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        num_r     <= num_instr_i;
                        cnt_r     <= '0;
                        wr_csum_r <= '0;
                        rd_csum_r <= '0;
                        error_r   <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (instr_v_i) begin
                        wr_csum_r <= wr_csum_r ^ instr_data_i;
                        cnt_r     <= last_w ? '0 : cnt_r + one_lp;
                    end
                end
                S_READ: begin
                    cnt_r <= cnt_r + one_lp;
                    if (rd_pend_r) rd_csum_r <= rd_csum_r ^ ucode_data_i;
                end
                S_DRAIN: begin
                    rd_csum_r <= rd_csum_r ^ ucode_data_i;
                    error_r   <= (wr_csum_r != (rd_csum_r ^ ucode_data_i));
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        instr_ready_o = 1'b0;
        ucode_v_o     = 1'b0;
        ucode_w_o     = 1'b0;
        ucode_addr_o  = '0;
        ucode_data_o  = '0;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        case (state_r)
            S_WRITE: begin
                instr_ready_o = 1'b1;
                ucode_v_o     = instr_v_i;
                ucode_w_o     = 1'b1;
                ucode_addr_o  = cnt_r[cce_pc_width_p-1:0];
                ucode_data_o  = instr_data_i;
                busy_o        = 1'b1;
            end
            S_READ: begin
                ucode_v_o    = 1'b1;
                ucode_addr_o = cnt_r[cce_pc_width_p-1:0];
                busy_o       = 1'b1;
            end
            S_DRAIN: busy_o = 1'b1;
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    assign error_o = error_r;

endmodule

// File: tb/tb_bp_cce_ucode_loader.sv
// Bench for bp_cce_ucode_loader: a RAM model answers ucode reads one cycle later
// and expected traffic/timing/error are derived from load size, gaps and corruption.
`timescale 1ns/1ps
module tb_bp_cce_ucode_loader;
    localparam int pc_w = 8;
    localparam int iw   = 48;

    logic            clk_i = 1'b0;
    logic            reset_i = 1'b0;
    logic            start_i = 1'b0;
    logic [pc_w:0]   num_instr_i = '0;
    logic [iw-1:0]   instr_data_i = '0;
    logic            instr_v_i = 1'b0;
    logic            instr_ready_o, ucode_v_o, ucode_w_o;
    logic [pc_w-1:0] ucode_addr_o;
    logic [iw-1:0]   ucode_data_o;
    logic [iw-1:0]   ucode_data_i = '0;
    logic            busy_o, done_o, error_o;

    bp_cce_ucode_loader #(.cce_pc_width_p(pc_w), .cce_instr_width_p(iw), .verify_p(1)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .num_instr_i(num_instr_i),
        .instr_data_i(instr_data_i), .instr_v_i(instr_v_i), .instr_ready_o(instr_ready_o),
        .ucode_v_o(ucode_v_o), .ucode_w_o(ucode_w_o), .ucode_addr_o(ucode_addr_o),
        .ucode_data_o(ucode_data_o), .ucode_data_i(ucode_data_i), .busy_o(busy_o),
        .done_o(done_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    // CCE instruction RAM model with optional readback corruption of one address.
    logic [iw-1:0] mem [0:255];
    logic          corrupt_en = 1'b0;
    int            corrupt_addr = 0;
    logic [iw-1:0] corrupt_val = '0;

    always @(posedge clk_i) begin
        if (ucode_v_o) begin
            if (ucode_w_o) mem[ucode_addr_o] <= ucode_data_o;
            else ucode_data_i <= (corrupt_en && int'(ucode_addr_o) == corrupt_addr) ? corrupt_val : mem[ucode_addr_o];
        end
    end

    int checks = 0;
    int errors = 0;

    logic [iw-1:0] words [0:511];
    int            n_wr, n_rd, done_cyc, done_at1, gap_viol;
    logic          done_err, timed_out;
    int            wr_addr [0:511];
    logic [iw-1:0] wr_dat  [0:511];
    int            wr_cyc  [0:511];
    int            rd_addr [0:511];
    int            rd_cyc  [0:511];

    function automatic logic [iw-1:0] rand_word();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[iw-1:0];
    endfunction

    function automatic logic exp_error(input int n);
        logic [iw-1:0] a, b;
        a = '0;
        b = '0;
        for (int i = 0; i < n; i++) begin
            a ^= words[i];
            b ^= (corrupt_en && i == corrupt_addr) ? corrupt_val : words[i];
        end
        return a != b;
    endfunction

    // Cycle of the first write, last write and DONE for a stream with a fixed gap.
    function automatic int exp_wr_cyc(input int i, input int gap);
        return 1 + i * (gap + 1);
    endfunction

    function automatic int exp_done_cyc(input int n, input int gap);
        if (n == 0) return 1;
        return exp_wr_cyc(n - 1, gap) + n + 2;
    endfunction

    // Drives start in cycle 0 and a stream of words[0..n-1] with gap idle cycles
    // between words; logs port traffic until done_o or a cycle budget expires.
    task automatic do_load(input int n, input int gap);
        int cyc, idx, gap_left, limit;
        bit hs, fin;
        n_wr = 0; n_rd = 0; done_cyc = -1; done_at1 = -1; gap_viol = 0;
        done_err = 1'b0; timed_out = 1'b0;
        limit = n * (gap + 2) + 40;
        @(posedge clk_i); #1;
        start_i = 1'b1;
        num_instr_i = 9'(n);
        idx = 0; gap_left = 0; cyc = 0; fin = 0;
        instr_v_i = (n > 0);
        instr_data_i = words[0];
        while (!fin) begin
            @(negedge clk_i);
            hs = instr_ready_o && instr_v_i;
            if (ucode_v_o && ucode_w_o) begin
                if (!instr_v_i) gap_viol++;
                if (n_wr < 512) begin
                    wr_addr[n_wr] = int'(ucode_addr_o);
                    wr_dat[n_wr]  = ucode_data_o;
                    wr_cyc[n_wr]  = cyc;
                end
                n_wr++;
            end
            if (ucode_v_o && !ucode_w_o) begin
                if (n_rd < 512) begin
                    rd_addr[n_rd] = int'(ucode_addr_o);
                    rd_cyc[n_rd]  = cyc;
                end
                n_rd++;
            end
            if (cyc == 1) done_at1 = int'(done_o);
            if (cyc > 0 && done_o) begin
                done_cyc = cyc; done_err = error_o; fin = 1;
            end else if (cyc >= limit) begin
                timed_out = 1'b1; fin = 1;
            end else begin
                @(posedge clk_i); #1;
                cyc++;
                start_i = 1'b0;
                if (hs) begin idx++; gap_left = gap; end
                if (gap_left > 0) begin instr_v_i = 1'b0; gap_left--; end
                else if (idx < n) begin instr_v_i = 1'b1; instr_data_i = words[idx]; end
                else instr_v_i = 1'b0;
            end
        end
        start_i = 1'b0;
        instr_v_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            checks++;
            if ({instr_ready_o, ucode_v_o, ucode_w_o, busy_o, done_o, error_o} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs got %b exp 000000",
                         {instr_ready_o, ucode_v_o, ucode_w_o, busy_o, done_o, error_o});
            end
        end
    endtask

    task automatic test_basic();
        words[0] = 48'h1; words[1] = 48'h2; words[2] = 48'h4; words[3] = 48'h8;
        corrupt_en = 1'b0;
        do_load(4, 0);
        checks++;
        if (timed_out !== 1'b0) begin errors++; $display("FAIL basic_timeout got %0b exp 0", timed_out); end
        checks++;
        if (n_wr !== 4) begin errors++; $display("FAIL basic_nwr got %0d exp 4", n_wr); end
        for (int i = 0; i < 4 && i < n_wr; i++) begin
            checks++;
            if (wr_addr[i] !== i || wr_dat[i] !== words[i] || wr_cyc[i] !== i + 1) begin
                errors++;
                $display("FAIL basic_wr[%0d] got a=%0d d=%0h c=%0d exp a=%0d d=%0h c=%0d",
                         i, wr_addr[i], wr_dat[i], wr_cyc[i], i, words[i], i + 1);
            end
        end
        checks++;
        if (n_rd !== 4) begin errors++; $display("FAIL basic_nrd got %0d exp 4", n_rd); end
        for (int i = 0; i < 4 && i < n_rd; i++) begin
            checks++;
            if (rd_addr[i] !== i || rd_cyc[i] !== 5 + i) begin
                errors++;
                $display("FAIL basic_rd[%0d] got a=%0d c=%0d exp a=%0d c=%0d", i, rd_addr[i], rd_cyc[i], i, 5 + i);
            end
        end
        checks++;
        if (done_cyc !== 10) begin errors++; $display("FAIL basic_done_cyc got %0d exp 10", done_cyc); end
        checks++;
        if (done_err !== 1'b0) begin errors++; $display("FAIL basic_error got %0b exp 0", done_err); end
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_done_hold got busy=%0b done=%0b exp busy=0 done=1", busy_o, done_o);
        end
    endtask

    task automatic test_mismatch();
        logic exp;
        corrupt_en = 1'b1; corrupt_addr = 2; corrupt_val = 48'h5;
        exp = exp_error(4);
        do_load(4, 0);
        checks++;
        if (done_cyc !== 10) begin errors++; $display("FAIL mismatch_done_cyc got %0d exp 10", done_cyc); end
        checks++;
        if (done_err !== exp) begin errors++; $display("FAIL mismatch_error got %0b exp %0b", done_err, exp); end
        corrupt_en = 1'b0;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) words[i] = rand_word();
        do_load(3, 2);
        checks++;
        if (n_wr !== 3) begin errors++; $display("FAIL stall_nwr got %0d exp 3", n_wr); end
        checks++;
        if (gap_viol !== 0) begin errors++; $display("FAIL stall_gap_write got %0d exp 0", gap_viol); end
        for (int i = 0; i < 3 && i < n_wr; i++) begin
            checks++;
            if (wr_addr[i] !== i || wr_dat[i] !== words[i] || wr_cyc[i] !== exp_wr_cyc(i, 2)) begin
                errors++;
                $display("FAIL stall_wr[%0d] got a=%0d d=%0h c=%0d exp a=%0d d=%0h c=%0d",
                         i, wr_addr[i], wr_dat[i], wr_cyc[i], i, words[i], exp_wr_cyc(i, 2));
            end
        end
        checks++;
        if (done_cyc !== exp_done_cyc(3, 2) || done_err !== 1'b0) begin
            errors++;
            $display("FAIL stall_done got c=%0d e=%0b exp c=%0d e=0", done_cyc, done_err, exp_done_cyc(3, 2));
        end
    endtask

    task automatic test_restart();
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b1) begin errors++; $display("FAIL restart_pre_done got %0b exp 1", done_o); end
        words[0] = rand_word();
        do_load(1, 0);
        checks++;
        if (done_at1 !== 0) begin errors++; $display("FAIL restart_done_drop got %0d exp 0", done_at1); end
        checks++;
        if (n_wr !== 1 || wr_addr[0] !== 0 || wr_dat[0] !== words[0]) begin
            errors++;
            $display("FAIL restart_write got n=%0d a=%0d d=%0h exp n=1 a=0 d=%0h", n_wr, wr_addr[0], wr_dat[0], words[0]);
        end
        checks++;
        if (done_cyc !== 4 || done_err !== 1'b0) begin
            errors++;
            $display("FAIL restart_done got c=%0d e=%0b exp c=4 e=0", done_cyc, done_err);
        end
    endtask

    task automatic test_n0();
        do_load(0, 0);
        checks++;
        if (done_cyc !== 1) begin errors++; $display("FAIL n0_done_cyc got %0d exp 1", done_cyc); end
        checks++;
        if (n_wr !== 0 || n_rd !== 0 || done_err !== 1'b0) begin
            errors++;
            $display("FAIL n0_activity got wr=%0d rd=%0d e=%0b exp wr=0 rd=0 e=0", n_wr, n_rd, done_err);
        end
    endtask

    task automatic test_n256();
        int bad_wr, bad_rd;
        for (int i = 0; i < 256; i++) words[i] = rand_word();
        do_load(256, 0);
        bad_wr = 0; bad_rd = 0;
        for (int i = 0; i < 256 && i < n_wr; i++) if (wr_addr[i] !== i || wr_dat[i] !== words[i]) bad_wr++;
        for (int i = 0; i < 256 && i < n_rd; i++) if (rd_addr[i] !== i) bad_rd++;
        checks++;
        if (n_wr !== 256 || bad_wr !== 0) begin
            errors++; $display("FAIL n256_writes got n=%0d bad=%0d exp n=256 bad=0", n_wr, bad_wr);
        end
        checks++;
        if (wr_addr[255] !== 255) begin errors++; $display("FAIL n256_last_addr got %0d exp 255", wr_addr[255]); end
        checks++;
        if (n_rd !== 256 || bad_rd !== 0) begin
            errors++; $display("FAIL n256_reads got n=%0d bad=%0d exp n=256 bad=0", n_rd, bad_rd);
        end
        checks++;
        if (done_cyc !== 514 || done_err !== 1'b0) begin
            errors++; $display("FAIL n256_done got c=%0d e=%0b exp c=514 e=0", done_cyc, done_err);
        end
    endtask

    task automatic test_random();
        int n, gap;
        logic exp;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 20);
            gap = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) words[i] = rand_word();
            corrupt_en = $urandom_range(0, 1) == 1;
            corrupt_addr = $urandom_range(0, n - 1);
            corrupt_val = rand_word();
            exp = exp_error(n);
            do_load(n, gap);
            checks++;
            if (n_wr !== n || n_rd !== n || gap_viol !== 0) begin
                errors++;
                $display("FAIL random%0d_traffic got wr=%0d rd=%0d gv=%0d exp wr=%0d rd=%0d gv=0",
                         it, n_wr, n_rd, gap_viol, n, n);
            end
            checks++;
            if (done_cyc !== exp_done_cyc(n, gap) || done_err !== exp) begin
                errors++;
                $display("FAIL random%0d_done got c=%0d e=%0b exp c=%0d e=%0b",
                         it, done_cyc, done_err, exp_done_cyc(n, gap), exp);
            end
        end
        corrupt_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int idx;
        bit found, hs;
        for (int i = 0; i < 4; i++) words[i] = rand_word();
        @(posedge clk_i); #1;
        start_i = 1'b1; num_instr_i = 9'd4;
        instr_v_i = 1'b1; instr_data_i = words[0];
        idx = 0; found = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk_i);
            hs = instr_ready_o && instr_v_i;
            if (ucode_v_o && !ucode_w_o && ucode_addr_o == 8'd1) found = 1;
            else begin
                @(posedge clk_i); #1;
                start_i = 1'b0;
                if (hs) idx++;
                instr_v_i = (idx < 4);
                if (idx < 4) instr_data_i = words[idx];
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rstmid_read1 got none exp read of addr 1"); end
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        reset_i = 1'b1; start_i = 1'b0; instr_v_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({ucode_v_o, busy_o, done_o} !== 3'b000) begin
            errors++; $display("FAIL rstmid_outputs got v/busy/done=%b exp 000", {ucode_v_o, busy_o, done_o});
        end
        do_load(4, 0);
        checks++;
        if (n_wr !== 4 || done_cyc !== 10 || done_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_reload got wr=%0d c=%0d e=%0b exp wr=4 c=10 e=0", n_wr, done_cyc, done_err);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_mismatch();
        test_stall();
        test_restart();
        test_n0();
        test_n256();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_cce_ucode_loader.md
Name: bp_cce_ucode_loader

Overview:
- Sequences the CCE microcode port. Streams N instructions from a ready/valid source into CCE instruction RAM at addresses 0..N-1.
- Optionally reads all N entries back and compares an XOR checksum of the read data against the checksum of the written data.
- Sits between the configuration/boot path and the CCE ucode_v/ucode_w/ucode_addr/ucode_data port. It is the only master of that port while the loader is busy.

Parameters:
- cce_pc_width_p, 8, CCE instruction RAM address width.
- cce_instr_width_p, 48, CCE instruction width.
- verify_p, 1, 1 = perform the readback/checksum phase; 0 = skip it.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-low reset (0 = reset).
- start_i  in  1  begin load. Sampled only in IDLE or DONE.
- num_instr_i  in  cce_pc_width_p+1  instruction count N, 0..2^cce_pc_width_p. Captured at start.
- instr_data_i  in  cce_instr_width_p  instruction stream data.
- instr_v_i  in  1  stream valid.
- instr_ready_o  out  1  stream ready.
- ucode_v_o  out  1  CCE ucode access valid. The CCE accepts every cycle; there is no backpressure.
- ucode_w_o  out  1  1 = write, 0 = read.
- ucode_addr_o  out  cce_pc_width_p  ucode RAM address.
- ucode_data_o  out  cce_instr_width_p  write data.
- ucode_data_i  in  cce_instr_width_p  read data, valid exactly 1 cycle after a read access.
- busy_o  out  1  high in WRITE/READ/DRAIN.
- done_o  out  1  high in DONE.
- error_o  out  1  checksum mismatch. Valid while done_o is high.

Behaviour:
- Reset (reset_i=0 at a clock edge):
  - state=IDLE; counter, N register, both checksums and the read-pending flag are cleared.
  - All outputs are 0.
  - Applies mid-operation: any in-flight write/read is abandoned, with no further ucode_v_o.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - instr_ready_o=0, ucode_v_o=0.
  - start_i=1: capture N, clear counter and checksums.
  - N=0 -> DONE with error_o=0 and no port activity; otherwise -> WRITE.
- WRITE:
  - instr_ready_o=1; ucode_v_o=instr_v_i, combinational pass-through.
  - ucode_w_o=1; ucode_addr_o=counter; ucode_data_o=instr_data_i.
  - On each handshake (instr_v_i=1): wr_csum ^= instr_data_i; counter++.
  - On the handshake with counter==N-1: counter cleared; next state READ if verify_p, else DONE with error_o=0.
  - Stream gaps (instr_v_i=0) stall with no write.
- READ:
  - ucode_v_o=1, ucode_w_o=0, ucode_addr_o=counter every cycle; counter++.
  - The read-pending flag is set the cycle after each read. When set, rd_csum ^= ucode_data_i.
  - After issuing the read at counter==N-1 -> DRAIN.
- DRAIN:
  - ucode_v_o=0. Folds the final read data into rd_csum.
  - -> DONE with error_o = (wr_csum != rd_csum ^ ucode_data_i).
- DONE:
  - done_o=1; error_o is held.
  - start_i=1 restarts exactly as from IDLE, and clears done_o/error_o on that edge.
- start_i is ignored in WRITE/READ/DRAIN.
- N=2^cce_pc_width_p: the counter addresses the last entry 2^cce_pc_width_p-1. The counter compare uses the cce_pc_width_p+1-bit register, so there is no wrap-around.
- Latency with an uninterrupted stream and start at cycle 0:
  - writes occur in cycles 1..N;
  - verify_p=1: reads in cycles N+1..2N, DRAIN at 2N+1, done_o=1 from cycle 2N+2;
  - verify_p=0: done_o=1 from cycle N+1.
- ucode_addr_o and ucode_data_o are don't-care when ucode_v_o=0. The bench must not check them then.

Test Plan:
- Reset/idle: hold reset_i=0 for 3 cycles, then release with no start. All outputs stay 0; instr_ready_o=0.
- Basic load, verify_p=1: N=4, data 0x1,0x2,0x4,0x8 streamed back-to-back.
  - Writes at addr 0..3 in cycles 1..4.
  - Reads at addr 0..3 in cycles 5..8.
  - done_o=1 at cycle 10 with error_o=0.
- Mismatch: same load, but the bench model corrupts the readback of addr 2 to 0x5. Expect done_o=1 with error_o=1.
- Stream stall and restart:
  - N=3 with instr_v_i low for 2 cycles between words. Exactly 3 writes, no write issued in the gap cycles, done_o=1.
  - Then start_i in DONE with N=1. done_o drops, 1 write to addr 0, done_o returns.
- Boundary counts:
  - N=0: done_o=1 the cycle after start with no ucode_v_o.
  - N=256 (cce_pc_width_p=8): last write addr 0xFF, no address wrap, 256 reads, error_o=0.
- Reset mid-load: reset_i=0 during the READ of addr 1 of N=4. The next cycle has ucode_v_o=0, busy_o=0, done_o=0; a new start completes normally.
